// File: rtl/cv32e40x_xif_kill_fifo.sv
// cv32e40x_xif_kill_fifo: tracking FIFO for X-interface offload instructions/results.
// Valid/ready on both sides, per-entry ID tag, almost-full threshold, flush and
// partial kill (keep the oldest N entries, drop the rest).
// Optional occupancy high-water mark on hwm_o when CV32E40X_FIFO_HWM_EN is defined;
// otherwise hwm_o is tied to zero and no register exists.

module cv32e40x_xif_kill_fifo #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FALL_THROUGH = 0,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                kill_valid_i,
    input  logic [CNT_W-1:0]    kill_keep_i,
    input  logic                push_valid_i,
    output logic                push_ready_o,
    input  logic [WIDTH-1:0]    push_data_i,
    input  logic [ID_WIDTH-1:0] push_id_i,
    output logic                pop_valid_o,
    input  logic                pop_ready_i,
    output logic [WIDTH-1:0]    pop_data_o,
    output logic [ID_WIDTH-1:0] pop_id_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                almost_full_o,
    output logic [CNT_W-1:0]    hwm_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam bit          FT_EN = (FALL_THROUGH != 0);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(DEPTH - 1);
    localparam logic [SUM_W-1:0] DEPTH_S    = SUM_W'(DEPTH);

    // State
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]    cnt_q,  cnt_d;
    logic [WIDTH-1:0]    mem_data_q [DEPTH];
    logic [ID_WIDTH-1:0] mem_id_q   [DEPTH];

    // Combinational control
    logic             blocked_c;
    logic             empty_c;
    logic             ft_active_c;
    logic             push_ready_c;
    logic             pop_valid_c;
    logic             push_fire_c;
    logic             pop_fire_c;
    logic             bypass_c;
    logic             store_c;
    logic [DEPTH-1:0] we_c;
    logic [CNT_W-1:0] kept_c;
    logic [SUM_W-1:0] wsum_c;

    // Wrap-around pointer increment; DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_PTR_C) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Handshake qualification; flush and kill block both sides for the cycle
    always_comb begin
        blocked_c    = flush_i | kill_valid_i;
        empty_c      = (cnt_q == '0);
        ft_active_c  = FT_EN & empty_c;
        push_ready_c = (cnt_q != DEPTH_C) & ~blocked_c;
        pop_valid_c  = (~empty_c | (FT_EN & push_valid_i)) & ~blocked_c;
        push_fire_c  = push_valid_i & push_ready_c;
        pop_fire_c   = pop_valid_c & pop_ready_i;
        bypass_c     = ft_active_c & push_fire_c & pop_fire_c;
        store_c      = push_fire_c & ~bypass_c;
    end

    // Head-of-queue read, or the push side itself when forwarding through an empty FIFO
    always_comb begin
        pop_data_o = mem_data_q[rptr_q];
        pop_id_o   = mem_id_q[rptr_q];
        if (ft_active_c) begin
            pop_data_o = push_data_i;
            pop_id_o   = push_id_i;
        end
    end

    // Next-state for pointers and count: flush > kill > normal push/pop
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        kept_c = cnt_q;
        wsum_c = '0;

        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else if (kill_valid_i) begin
            // Keep the oldest entries; write pointer rewinds to just past them
            kept_c = (kill_keep_i < cnt_q) ? kill_keep_i : cnt_q;
            wsum_c = SUM_W'(rptr_q) + SUM_W'(kept_c);
            if (wsum_c >= DEPTH_S) begin
                wsum_c = wsum_c - DEPTH_S;
            end
            wptr_d = PTR_W'(wsum_c);
            cnt_d  = kept_c;
        end else if (!bypass_c) begin
            if (push_fire_c) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop_fire_c) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({push_fire_c, pop_fire_c})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Per-entry write enable: only the slot under the write pointer
    always_comb begin
        we_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            we_c[i] = store_c & (wptr_q == PTR_W'(i));
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage, one enabled register pair per slot
    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        // Capture payload and tag when this slot is addressed by an accepted push
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_data_q[g] <= '0;
                mem_id_q[g]   <= '0;
            end else if (we_c[g]) begin
                mem_data_q[g] <= push_data_i;
                mem_id_q[g]   <= push_id_i;
            end
        end
    end

`ifdef CV32E40X_FIFO_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    // High-water mark tracks the peak next-cycle occupancy; cleared only by flush
    always_comb begin
        hwm_d = hwm_q;
        if (flush_i) begin
            hwm_d = '0;
        end else if (cnt_d > hwm_q) begin
            hwm_d = cnt_d;
        end
    end

    // High-water mark register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

    assign push_ready_o  = push_ready_c;
    assign pop_valid_o   = pop_valid_c;
    assign cnt_o         = cnt_q;
    assign almost_full_o = (cnt_q >= THRESH_C);

endmodule

// File: tb/tb_cv32e40x_xif_kill_fifo.sv
// Bench for cv32e40x_xif_kill_fifo: two instances (DEPTH=4 plain, DEPTH=3 fall-through)
// share stimulus; a queue-based model predicts every observable output.

module tb_cv32e40x_xif_kill_fifo;

    localparam int unsigned W  = 32;
    localparam int unsigned IW = 4;

`ifdef CV32E40X_FIFO_HWM_EN
    localparam bit HWM_ON = 1'b1;
`else
    localparam bit HWM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush, kill_valid, push_valid, pop_ready;
    logic [2:0]    keep_a;
    logic [1:0]    keep_b;
    logic [W-1:0]  push_data;
    logic [IW-1:0] push_id;

    logic          a_push_ready, a_pop_valid, a_afull;
    logic [W-1:0]  a_pop_data;
    logic [IW-1:0] a_pop_id;
    logic [2:0]    a_cnt, a_hwm;

    logic          b_push_ready, b_pop_valid, b_afull;
    logic [W-1:0]  b_pop_data;
    logic [IW-1:0] b_pop_id;
    logic [1:0]    b_cnt, b_hwm;

    int passed = 0;
    int total  = 0;

    ent_t qa[$];
    ent_t qb[$];
    int   hwm_a = 0;
    int   hwm_b = 0;

    cv32e40x_xif_kill_fifo #(.WIDTH(W), .ID_WIDTH(IW), .DEPTH(4), .FALL_THROUGH(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .kill_valid_i(kill_valid),
        .kill_keep_i(keep_a), .push_valid_i(push_valid), .push_ready_o(a_push_ready),
        .push_data_i(push_data), .push_id_i(push_id), .pop_valid_o(a_pop_valid),
        .pop_ready_i(pop_ready), .pop_data_o(a_pop_data), .pop_id_o(a_pop_id),
        .cnt_o(a_cnt), .almost_full_o(a_afull), .hwm_o(a_hwm)
    );

    cv32e40x_xif_kill_fifo #(.WIDTH(W), .ID_WIDTH(IW), .DEPTH(3), .FALL_THROUGH(1),
                             .AFULL_THRESH(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .kill_valid_i(kill_valid),
        .kill_keep_i(keep_b), .push_valid_i(push_valid), .push_ready_o(b_push_ready),
        .push_data_i(push_data), .push_id_i(push_id), .pop_valid_o(b_pop_valid),
        .pop_ready_i(pop_ready), .pop_data_o(b_pop_data), .pop_id_o(b_pop_id),
        .cnt_o(b_cnt), .almost_full_o(b_afull), .hwm_o(b_hwm)
    );

    // Expected combinational/registered outputs for instance 0 (A) or 1 (B)
    task automatic model_out(input int which, output bit pr, output bit pv, output ent_t head,
                             output int cnt, output bit af, output int hwm);
        int d, thr, n;
        bit ft;
        head = {push_id, push_data};
        if (which == 0) begin
            d = 4; thr = 3; ft = 1'b0; n = qa.size(); hwm = hwm_a;
            if (n > 0) head = qa[0];
        end else begin
            d = 3; thr = 2; ft = 1'b1; n = qb.size(); hwm = hwm_b;
            if (n > 0) head = qb[0];
        end
        pr  = (n != d) && !flush && !kill_valid;
        pv  = ((n != 0) || (ft && push_valid)) && !flush && !kill_valid;
        cnt = n;
        af  = (n >= thr);
        if (!HWM_ON) hwm = 0;
    endtask

    // Advance one instance's model by one clock using the current inputs
    task automatic model_step(input int which);
        ent_t q[$];
        ent_t h;
        bit   pr, pv, af, pf, pp;
        int   c, hw, keep, hwm;
        model_out(which, pr, pv, h, c, af, hw);
        if (which == 0) begin q = qa; keep = int'(keep_a); hwm = hwm_a; end
        else            begin q = qb; keep = int'(keep_b); hwm = hwm_b; end
        pf = push_valid && pr;
        pp = pv && pop_ready;
        if (flush) begin
            q.delete();
            hwm = 0;
        end else if (kill_valid) begin
            while (q.size() > keep) void'(q.pop_back());
        end else if (!(pp && q.size() == 0)) begin
            if (pp) void'(q.pop_front());
            if (pf) q.push_back({push_id, push_data});
        end
        if (q.size() > hwm) hwm = q.size();
        if (which == 0) begin qa = q; hwm_a = hwm; end
        else            begin qb = q; hwm_b = hwm; end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit pv, input logic [IW-1:0] id, input logic [W-1:0] data,
                         input bit prd, input bit fl, input bit kv, input logic [2:0] kk);
        push_valid = pv;
        push_id    = id;
        push_data  = data;
        pop_ready  = prd;
        flush      = fl;
        kill_valid = kv;
        keep_a     = kk;
        keep_b     = kk[1:0];
        #1;
    endtask

    task automatic do_flush();
        drive(0, 0, 0, 0, 1, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (a_push_ready !== 1'b1) $display("FAIL reset_a_push_ready got %b exp 1", a_push_ready); else passed++;
        total++; if (a_pop_valid !== 1'b0) $display("FAIL reset_a_pop_valid got %b exp 0", a_pop_valid); else passed++;
        total++; if (a_cnt !== 3'd0 || a_afull !== 1'b0 || a_hwm !== 3'd0)
            $display("FAIL reset_a_state got cnt=%0d af=%b hwm=%0d exp 0/0/0", a_cnt, a_afull, a_hwm); else passed++;
        total++; if (a_pop_data !== 32'd0 || a_pop_id !== 4'd0)
            $display("FAIL reset_a_head got %h/%h exp 0/0", a_pop_data, a_pop_id); else passed++;
        total++; if (b_push_ready !== 1'b1 || b_pop_valid !== 1'b0 || b_cnt !== 2'd0)
            $display("FAIL reset_b got pr=%b pv=%b cnt=%0d exp 1/0/0", b_push_ready, b_pop_valid, b_cnt); else passed++;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // DEPTH=3 fill, overflow attempt, drain and pointer wrap
    task automatic test_fill_wrap();
        do_flush();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 4'(i), 32'h100 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        total++; if (b_cnt !== 2'd3 || b_push_ready !== 1'b0 || b_afull !== 1'b1)
            $display("FAIL fill_full got cnt=%0d pr=%b af=%b exp 3/0/1", b_cnt, b_push_ready, b_afull); else passed++;
        drive(1, 4'd4, 32'h104, 0, 0, 0, 0);
        total++; if (b_push_ready !== 1'b0) $display("FAIL fill_overflow_ready got %b exp 0", b_push_ready); else passed++;
        tick();
        total++; if (b_cnt !== 2'd3) $display("FAIL fill_overflow_cnt got %0d exp 3", b_cnt); else passed++;
        for (int k = 1; k <= 2; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            total++; if (b_pop_valid !== 1'b1 || b_pop_id !== 4'(k))
                $display("FAIL fill_pop got v=%b id=%0d exp 1/%0d", b_pop_valid, b_pop_id, k); else passed++;
            tick();
        end
        drive(1, 4'd10, 32'h10A, 0, 0, 0, 0);
        tick();
        total++; if (b_cnt !== 2'd2) $display("FAIL wrap_cnt got %0d exp 2", b_cnt); else passed++;
        drive(0, 0, 0, 1, 0, 0, 0);
        total++; if (b_pop_id !== 4'd3 || b_pop_data !== 32'h103)
            $display("FAIL wrap_pop3 got %0d/%h exp 3/103", b_pop_id, b_pop_data); else passed++;
        tick();
        total++; if (b_pop_id !== 4'd10 || b_pop_data !== 32'h10A)
            $display("FAIL wrap_pop10 got %0d/%h exp 10/10a", b_pop_id, b_pop_data); else passed++;
        tick();
        total++; if (b_cnt !== 2'd0) $display("FAIL wrap_empty got %0d exp 0", b_cnt); else passed++;
    endtask

    // DEPTH=4 steady streaming with 3 entries resident
    task automatic test_stream();
        int np, nq;
        np = 0; nq = 0;
        do_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(np), 32'hC000 + 32'(np), 0, 0, 0, 0);
            np++;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'(np), 32'hC000 + 32'(np), 1, 0, 0, 0);
            np++;
            total++; if (a_cnt !== 3'd3 || a_pop_id !== 4'(nq) || a_pop_data !== 32'hC000 + 32'(nq))
                $display("FAIL stream got cnt=%0d id=%0d data=%h exp 3/%0d/%h",
                         a_cnt, a_pop_id, a_pop_data, nq, 32'hC000 + 32'(nq)); else passed++;
            nq++;
            tick();
        end
        total++; if (a_cnt !== 3'd3) $display("FAIL stream_end_cnt got %0d exp 3", a_cnt); else passed++;
    endtask

    // Partial kill, kill no-op and kill-to-zero
    task automatic test_kill();
        logic [IW-1:0] exp_ids [3];
        exp_ids[0] = 4'd5; exp_ids[1] = 4'd6; exp_ids[2] = 4'd9;
        do_flush();
        for (int i = 5; i <= 8; i++) begin
            drive(1, 4'(i), 32'hD00 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        total++; if (a_cnt !== 3'd4) $display("FAIL kill_pre_cnt got %0d exp 4", a_cnt); else passed++;
        drive(1, 4'd15, 32'hDEAD, 1, 0, 1, 3'd2);
        total++; if (a_push_ready !== 1'b0 || a_pop_valid !== 1'b0)
            $display("FAIL kill_block got pr=%b pv=%b exp 0/0", a_push_ready, a_pop_valid); else passed++;
        tick();
        total++; if (a_cnt !== 3'd2) $display("FAIL kill_cnt got %0d exp 2", a_cnt); else passed++;
        drive(1, 4'd9, 32'hD09, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            total++; if (a_pop_valid !== 1'b1 || a_pop_id !== exp_ids[k])
                $display("FAIL kill_pop got v=%b id=%0d exp 1/%0d", a_pop_valid, a_pop_id, exp_ids[k]); else passed++;
            tick();
        end
        do_flush();
        drive(1, 4'd1, 32'hE01, 0, 0, 0, 0); tick();
        drive(1, 4'd2, 32'hE02, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 3'd7); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (a_cnt !== 3'd2 || a_pop_id !== 4'd1 || a_pop_valid !== 1'b1)
            $display("FAIL kill_noop got cnt=%0d id=%0d v=%b exp 2/1/1", a_cnt, a_pop_id, a_pop_valid); else passed++;
        drive(0, 0, 0, 0, 0, 1, 3'd0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (a_cnt !== 3'd0 || a_pop_valid !== 1'b0)
            $display("FAIL kill_zero got cnt=%0d v=%b exp 0/0", a_cnt, a_pop_valid); else passed++;
    endtask

    // Fall-through forwarding on the DEPTH=3 instance
    task automatic test_fall_through();
        do_flush();
        drive(1, 4'd3, 32'h3333, 1, 0, 0, 0);
        total++; if (b_pop_valid !== 1'b1 || b_pop_id !== 4'd3 || b_pop_data !== 32'h3333)
            $display("FAIL ft_forward got v=%b id=%0d data=%h exp 1/3/3333", b_pop_valid, b_pop_id, b_pop_data); else passed++;
        total++; if (a_pop_valid !== 1'b0) $display("FAIL ft_nonft_valid got %b exp 0", a_pop_valid); else passed++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (b_cnt !== 2'd0 || a_cnt !== 3'd1)
            $display("FAIL ft_cnt got b=%0d a=%0d exp 0/1", b_cnt, a_cnt); else passed++;
    endtask

    // High-water mark across fill/drain and flush
    task automatic test_hwm();
        do_flush();
        total++; if (a_hwm !== 3'd0) $display("FAIL hwm_flush0 got %0d exp 0", a_hwm); else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(i), 32'hF00 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            tick();
        end
        total++; if (a_cnt !== 3'd0 || a_hwm !== (HWM_ON ? 3'd3 : 3'd0))
            $display("FAIL hwm_peak got cnt=%0d hwm=%0d exp 0/%0d", a_cnt, a_hwm, HWM_ON ? 3 : 0); else passed++;
        total++; if (b_hwm !== (HWM_ON ? 2'd3 : 2'd0))
            $display("FAIL hwm_peak_b got %0d exp %0d", b_hwm, HWM_ON ? 3 : 0); else passed++;
        do_flush();
        total++; if (a_hwm !== 3'd0) $display("FAIL hwm_clear got %0d exp 0", a_hwm); else passed++;
    endtask

    // Randomised traffic against the queue model on both instances
    task automatic test_random(input int cycles);
        bit   epr, epv, eaf;
        ent_t eh;
        int   ec, ehw;
        bit   heavy_push;
        for (int i = 0; i < cycles; i++) begin
            heavy_push = ((i / 64) % 2) == 0;
            drive($urandom_range(0, 3) != 0,
                  4'($urandom), $urandom,
                  heavy_push ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 15) == 0,
                  3'($urandom_range(0, 7)));
            model_out(0, epr, epv, eh, ec, eaf, ehw);
            total++; if (a_push_ready !== epr || a_pop_valid !== epv || a_cnt !== 3'(ec) ||
                         a_afull !== eaf || a_hwm !== 3'(ehw))
                $display("FAIL rand_a_ctrl cyc %0d got pr=%b pv=%b cnt=%0d af=%b hwm=%0d exp %b/%b/%0d/%b/%0d",
                         i, a_push_ready, a_pop_valid, a_cnt, a_afull, a_hwm, epr, epv, ec, eaf, ehw); else passed++;
            if (epv) begin
                total++; if (a_pop_id !== eh.id || a_pop_data !== eh.data)
                    $display("FAIL rand_a_head cyc %0d got %0d/%h exp %0d/%h", i, a_pop_id, a_pop_data, eh.id, eh.data); else passed++;
            end
            model_out(1, epr, epv, eh, ec, eaf, ehw);
            total++; if (b_push_ready !== epr || b_pop_valid !== epv || b_cnt !== 2'(ec) ||
                         b_afull !== eaf || b_hwm !== 2'(ehw))
                $display("FAIL rand_b_ctrl cyc %0d got pr=%b pv=%b cnt=%0d af=%b hwm=%0d exp %b/%b/%0d/%b/%0d",
                         i, b_push_ready, b_pop_valid, b_cnt, b_afull, b_hwm, epr, epv, ec, eaf, ehw); else passed++;
            if (epv) begin
                total++; if (b_pop_id !== eh.id || b_pop_data !== eh.data)
                    $display("FAIL rand_b_head cyc %0d got %0d/%h exp %0d/%h", i, b_pop_id, b_pop_data, eh.id, eh.data); else passed++;
            end
            tick();
        end
    endtask

    // Asynchronous reset in the middle of a cycle, then resume
    task automatic test_reset_mid();
        do_flush();
        drive(1, 4'd7, 32'h777, 0, 0, 0, 0); tick();
        drive(1, 4'd8, 32'h888, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        total++; if (a_cnt !== 3'd0 || a_pop_valid !== 1'b0 || b_cnt !== 2'd0)
            $display("FAIL reset_mid got a=%0d v=%b b=%0d exp 0/0/0", a_cnt, a_pop_valid, b_cnt); else passed++;
        qa.delete(); qb.delete(); hwm_a = 0; hwm_b = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 4'd12, 32'hC0C0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++; if (a_pop_id !== 4'd12 || a_pop_data !== 32'hC0C0 || a_cnt !== 3'd1)
            $display("FAIL reset_resume got %0d/%h cnt=%0d exp 12/c0c0/1", a_pop_id, a_pop_data, a_cnt); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_stream();
        test_kill();
        test_fall_through();
        test_hwm();
        test_random(800);
        test_reset_mid();
        test_random(200);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
